// File: rtl/quad_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_pkg
// Description : Shared types and helpers for the quadrature encoder bank:
//               step direction enum, AB transition decoder and the
//               accumulator width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package quad_encoder_pkg;

  // Result of comparing two consecutive AB samples
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2,
    DIR_ERR  = 2'd3
  } dir_t;

  // Signed accumulator must hold +/-STEPS_PER_DETENT plus a sign bit
  function automatic int acc_width(input int steps);
    return $clog2(steps) + 2;
  endfunction

  // Classify one AB transition ({A,B} order); A leading B is clockwise
  function automatic dir_t decode(input logic [1:0] prev, input logic [1:0] cur);
    dir_t dir;
    dir = DIR_NONE;
    if ((prev ^ cur) == 2'b11) begin
      dir = DIR_ERR;
    end else if (prev != cur) begin
      case ({prev, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dir = DIR_CW;
        default:                                 dir = DIR_CCW;
      endcase
    end
    return dir;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_channel.sv
`default_nettype none
// ============================================================================
// Module      : quad_channel
// Description : One quadrature channel: AB history, signed step accumulator,
//               detent pulses, position counter and sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_channel
  import quad_encoder_pkg::*;
#(
  parameter int COUNT_W          = 8,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               a_i,
  input  logic               b_i,
  input  logic               clear_i,
  output logic               left_o,
  output logic               right_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               error_o
);

  localparam int                        ACC_W      = acc_width(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0]   c_ACC_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0]   c_ACC_LAST = ACC_W'(STEPS_PER_DETENT - 1);
  localparam logic        [COUNT_W-1:0] c_CNT_ONE  = COUNT_W'(1);
  localparam logic        [COUNT_W-1:0] c_CNT_MAX  = '1;

  logic                      valid_q;
  logic [1:0]                cur_q;
  logic [1:0]                prev_q;
  logic signed [ACC_W-1:0]   acc_q,   acc_d;
  logic [COUNT_W-1:0]        count_q, count_d;
  logic                      err_q,   err_d;
  logic                      left_q,  left_d;
  logic                      right_q, right_d;
  dir_t                      step_dir;
  logic [COUNT_W-1:0]        count_inc;
  logic [COUNT_W-1:0]        count_dec;

  // Saturating variants only differ at the limits; the pulse is still emitted
  assign count_inc = ((WRAP != 0) || (count_q != c_CNT_MAX)) ? count_q + c_CNT_ONE : count_q;
  assign count_dec = ((WRAP != 0) || (count_q != '0))        ? count_q - c_CNT_ONE : count_q;

  // Decode last transition, advance accumulator and emit detent pulses
  always_comb begin
    step_dir = decode(prev_q, cur_q);
    acc_d    = acc_q;
    count_d  = count_q;
    err_d    = err_q;
    left_d   = 1'b0;
    right_d  = 1'b0;
    if (valid_q) begin
      unique case (step_dir)
        DIR_CW: begin
          if (acc_q == c_ACC_LAST) begin
            acc_d   = '0;
            right_d = 1'b1;
            count_d = count_inc;
          end else begin
            acc_d = acc_q + c_ACC_ONE;
          end
        end
        DIR_CCW: begin
          if (acc_q == -c_ACC_LAST) begin
            acc_d   = '0;
            left_d  = 1'b1;
            count_d = count_dec;
          end else begin
            acc_d = acc_q - c_ACC_ONE;
          end
        end
        DIR_ERR: begin
          acc_d = '0;
          err_d = 1'b1;
        end
        default: ;
      endcase
    end
    // Clear wipes state and swallows the pulse, but a fresh error still lands
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
      left_d  = 1'b0;
      right_d = 1'b0;
      err_d   = valid_q && (step_dir == DIR_ERR);
    end
  end

  // State registers; first edge after reset only captures the pins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      cur_q   <= '0;
      prev_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      if (!valid_q) begin
        valid_q <= 1'b1;
        cur_q   <= {a_i, b_i};
        prev_q  <= {a_i, b_i};
      end else begin
        prev_q  <= cur_q;
        cur_q   <= {a_i, b_i};
      end
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left_o  = left_q;
  assign right_o = right_q;
  assign count_o = count_q;
  assign error_o = err_q;

endmodule
`default_nettype wire

// File: rtl/quad_encoder_bank.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_bank
// Description : Bank of independent quadrature decoders. Each channel turns a
//               debounced A/B pair into CW/CCW detent pulses, a position
//               counter and a sticky illegal-transition flag.
//               STEPS_PER_DETENT must be 1, 2 or 4.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_bank
  import quad_encoder_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int COUNT_W          = 8,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 1
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic [CHANNELS-1:0]         i_A,
  input  logic [CHANNELS-1:0]         i_B,
  input  logic [CHANNELS-1:0]         i_Clear,
  output logic [CHANNELS-1:0]         o_Left,
  output logic [CHANNELS-1:0]         o_Right,
  output logic [CHANNELS*COUNT_W-1:0] o_Count,
  output logic [CHANNELS-1:0]         o_Error
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    quad_channel #(
      .COUNT_W          (COUNT_W),
      .STEPS_PER_DETENT (STEPS_PER_DETENT),
      .WRAP             (WRAP)
    ) u_ch (
      .clk_i   (i_Clk),
      .rst_i   (i_Rst),
      .a_i     (i_A[c]),
      .b_i     (i_B[c]),
      .clear_i (i_Clear[c]),
      .left_o  (o_Left[c]),
      .right_o (o_Right[c]),
      .count_o (o_Count[c*COUNT_W +: COUNT_W]),
      .error_o (o_Error[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_encoder_bank
// Description : Scoreboard bench for quad_encoder_bank. Three instances:
//               dut 0 = 4 steps/detent wrapping, dut 1 = 1 step/detent,
//               dut 2 = 4 steps/detent saturating. All 2 channels x 4 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_bank;

  typedef struct {
    bit right;
    int cnt;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a   [3];
  logic [1:0] b   [3];
  logic [1:0] clr [3];
  logic [1:0] lft [3];
  logic [1:0] rgt [3];
  logic [1:0] err [3];
  logic [7:0] cnt [3];

  int   cyc    = 0;
  int   t_set  = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq [6][$];
  exp_t m_e;

  always #5 clk = ~clk;

  // Cycle stamp used to check pulse latency
  always @(posedge clk) cyc <= cyc + 1;

  quad_encoder_bank #(.CHANNELS(2), .COUNT_W(4), .STEPS_PER_DETENT(4), .WRAP(1)) u_dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_A(a[0]), .i_B(b[0]), .i_Clear(clr[0]),
    .o_Left(lft[0]), .o_Right(rgt[0]), .o_Count(cnt[0]), .o_Error(err[0]));

  quad_encoder_bank #(.CHANNELS(2), .COUNT_W(4), .STEPS_PER_DETENT(1), .WRAP(1)) u_dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_A(a[1]), .i_B(b[1]), .i_Clear(clr[1]),
    .o_Left(lft[1]), .o_Right(rgt[1]), .o_Count(cnt[1]), .o_Error(err[1]));

  quad_encoder_bank #(.CHANNELS(2), .COUNT_W(4), .STEPS_PER_DETENT(4), .WRAP(0)) u_dut2 (
    .i_Clk(clk), .i_Rst(rst), .i_A(a[2]), .i_B(b[2]), .i_Clear(clr[2]),
    .o_Left(lft[2]), .o_Right(rgt[2]), .o_Count(cnt[2]), .o_Error(err[2]));

  // Monitor: every pulse seen must match the head of its channel's queue
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (lft[d][ch] || rgt[d][ch]) begin
            checks++;
            if (lft[d][ch] && rgt[d][ch]) begin
              errors++;
              $display("FAIL both_pulses dut%0d ch%0d: left and right high at cycle %0d, required at most one", d, ch, cyc);
            end else if (sbq[d*2+ch].size() == 0) begin
              errors++;
              $display("FAIL unexpected_pulse dut%0d ch%0d: got right=%0d count=%0d at cycle %0d, required no pulse",
                       d, ch, rgt[d][ch], cnt[d][ch*4 +: 4], cyc);
            end else begin
              m_e = sbq[d*2+ch].pop_front();
              if (rgt[d][ch] != m_e.right || int'(cnt[d][ch*4 +: 4]) != m_e.cnt || cyc != m_e.cyc) begin
                errors++;
                $display("FAIL pulse dut%0d ch%0d: got right=%0d count=%0d cycle=%0d, required right=%0d count=%0d cycle=%0d",
                         d, ch, rgt[d][ch], cnt[d][ch*4 +: 4], cyc, m_e.right, m_e.cnt, m_e.cyc);
              end
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ab(input int d, input int ch, input logic [1:0] ab);
    a[d][ch] = ab[1];
    b[d][ch] = ab[0];
    t_set    = cyc;
  endtask

  // Pulse from the last set_ab is visible two edges after it is sampled
  task automatic expect_pulse(input int d, input int ch, input bit right, input int count);
    exp_t e;
    e = '{right, count, t_set + 2};
    sbq[d*2+ch].push_back(e);
  endtask

  task automatic clear(input int d, input int ch);
    clr[d][ch] = 1'b1;
    hold(1);
    clr[d][ch] = 1'b0;
    hold(2);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] cw   [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] ccw  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] rev  [4] = '{2'b10, 2'b11, 2'b10, 2'b00};
  logic [1:0] cw11 [4] = '{2'b01, 2'b00, 2'b10, 2'b11};

  initial begin
    for (int d = 0; d < 3; d++) begin
      a[d] = 2'b11; b[d] = 2'b11; clr[d] = 2'b00;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after release with AB=11: nothing moves
    hold(20);
    @(negedge clk);
    check("idle_count_dut0", cnt[0], 8'h00);
    check("idle_error_dut0", err[0], 2'b00);
    check("idle_count_dut1", cnt[1], 8'h00);
    check("idle_count_dut2", cnt[2], 8'h00);
    realign();

    // Walk ch0 to 00 and clear the partial detent; dut1 counts every step
    set_ab(0, 0, 2'b01); set_ab(1, 0, 2'b01); expect_pulse(1, 0, 1, 1); hold(3);
    set_ab(0, 0, 2'b00); set_ab(1, 0, 2'b00); expect_pulse(1, 0, 1, 2); hold(3);
    clear(0, 0);
    clear(1, 0);
    for (int i = 0; i < 4; i++) begin
      set_ab(0, 0, cw[i]);
      if (i == 3) expect_pulse(0, 0, 1, 1);
      set_ab(1, 0, cw[i]);
      expect_pulse(1, 0, 1, i + 1);
      hold(3);
    end
    @(negedge clk);
    check("cw_detent_count_dut0", cnt[0], 8'h01);
    check("cw_steps_count_dut1", cnt[1], 8'h04);
    realign();

    // Four CCW detents from 0: wrap on dut0, saturate on dut2
    clear(0, 0);
    set_ab(2, 0, 2'b10); hold(3);
    set_ab(2, 0, 2'b00); hold(3);
    clear(2, 0);
    for (int det = 0; det < 4; det++) begin
      for (int i = 0; i < 4; i++) begin
        set_ab(0, 0, ccw[i]);
        set_ab(2, 0, ccw[i]);
        if (i == 3) begin
          expect_pulse(0, 0, 0, (16 + 15 - det) % 16);
          expect_pulse(2, 0, 0, 0);
        end
        hold(3);
      end
    end
    @(negedge clk);
    check("ccw_wrap_count_dut0", cnt[0], 8'h0C);
    check("ccw_sat_count_dut2", cnt[2], 8'h00);
    realign();

    // Reversal inside a detent on ch0 while ch1 completes a CW detent
    for (int i = 0; i < 4; i++) begin
      set_ab(0, 0, rev[i]);
      set_ab(0, 1, cw11[i]);
      if (i == 3) expect_pulse(0, 1, 1, 1);
      hold(3);
    end
    @(negedge clk);
    check("reversal_count_dut0", cnt[0], 8'h1C);
    check("reversal_error_dut0", err[0], 2'b00);
    realign();

    // Illegal double change, then a legal detent, then clear
    set_ab(0, 0, 2'b11); hold(3);
    @(negedge clk);
    check("err_set_dut0", err[0], 2'b01);
    realign();
    for (int i = 0; i < 4; i++) begin
      set_ab(0, 0, cw11[i]);
      if (i == 3) expect_pulse(0, 0, 1, 13);
      hold(3);
    end
    @(negedge clk);
    check("err_sticky_dut0", err[0], 2'b01);
    check("after_err_count_dut0", cnt[0], 8'h1D);
    realign();
    clear(0, 0);
    @(negedge clk);
    check("clear_count_dut0", cnt[0], 8'h10);
    check("clear_error_dut0", err[0], 2'b00);
    realign();

    // Error decoded on the same edge as clear still sets the flag
    set_ab(0, 0, 2'b00); hold(1);
    clr[0][0] = 1'b1; hold(1);
    clr[0][0] = 1'b0; hold(2);
    @(negedge clk);
    check("set_over_clear_error", err[0], 2'b01);
    check("set_over_clear_count", cnt[0], 8'h10);
    realign();
    clear(0, 0);

    // Async reset mid-detent, checked before the next clock edge
    set_ab(0, 0, 2'b10); hold(3);
    set_ab(0, 0, 2'b11); hold(3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_count_dut0", cnt[0], 8'h00);
    check("rst_async_count_dut1", cnt[1], 8'h00);
    check("rst_async_error_dut0", err[0], 2'b00);
    check("rst_async_pulses_dut0", {lft[0], rgt[0]}, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(3);
    set_ab(0, 0, 2'b01); hold(3);
    set_ab(0, 0, 2'b00); hold(3);
    @(negedge clk);
    check("post_rst_count_dut0", cnt[0], 8'h00);
    check("post_rst_error_dut0", err[0], 2'b00);
    hold(2);

    for (int q = 0; q < 6; q++) begin
      check($sformatf("pending_pulses_q%0d", q), sbq[q].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quad_encoder_bank.md
Name: quad_encoder_bank

Overview:
Multi-channel rotary/quadrature encoder decoder that turns debounced A/B pairs into one-cycle Left/Right detent pulses. It also keeps a per-channel position counter and flags illegal transitions.
Sits downstream of the per-pin debouncers and feeds the TM1638 display/menu logic. It replaces the single-channel, single-step rotary decoder used today.

Parameters:
CHANNELS, 4, number of independent encoders (1..16)
COUNT_W, 8, width of each position counter (2..16)
STEPS_PER_DETENT, 4, valid quadrature transitions per detent; legal values 1, 2, 4
WRAP, 1, 1 = counter wraps modulo 2^COUNT_W; 0 = saturates at 0 and 2^COUNT_W-1

Ports:
i_Clk  in  1  system clock; all state on posedge
i_Rst  in  1  asynchronous, active-high reset
i_A  in  CHANNELS  debounced A phase, one bit per channel
i_B  in  CHANNELS  debounced B phase, one bit per channel
i_Clear  in  CHANNELS  per-channel synchronous clear of count, step accumulator and error
o_Left  out  CHANNELS  one-cycle pulse per completed CCW detent
o_Right  out  CHANNELS  one-cycle pulse per completed CW detent
o_Count  out  CHANNELS*COUNT_W  position counters; channel c at [c*COUNT_W +: COUNT_W]
o_Error  out  CHANNELS  sticky illegal-transition flag

Behaviour:
- One clock; reset is asynchronous and active-high. i_Rst asserted forces all outputs and internal state to 0 immediately, with no clock edge needed; this includes the r_Valid init flag.
- Inputs are already synchronous (debounced in the i_Clk domain); no extra synchronizer.
- Per channel, registers r_Cur (AB) and r_Prev (AB).
- First posedge after reset release (r_Valid=0): load both r_Cur and r_Prev from {i_A,i_B} and set r_Valid. No decode happens that cycle, so no spurious step is counted from the reset value.
- Every later edge: r_Prev<=r_Cur, r_Cur<={i_A,i_B}.
- Decode of {r_Prev,r_Cur}, with AB written as {A,B}:
  - CW steps: 00->10, 10->11, 11->01, 01->00 (A leads B).
  - CCW steps: the reverse transitions.
  - No change: NONE.
  - Both bits changed: ERR.
- Step accumulator is signed, width $clog2(STEPS_PER_DETENT)+2, reset 0.
  - CW: +1. CCW: -1. A reversal inside a detent therefore cancels and produces no pulse.
  - Reaching +STEPS_PER_DETENT: accumulator<=0, o_Right pulses, count+1.
  - Reaching -STEPS_PER_DETENT: accumulator<=0, o_Left pulses, count-1.
- ERR: accumulator<=0, no pulse, o_Error<=1; it stays set until i_Clear or reset.
- Latency: a new AB value sampled at edge k is decoded at edge k+1. o_Left/o_Right are registered and high for exactly the cycle between edges k+1 and k+2. o_Count updates at edge k+1.
- o_Left and o_Right are never both high on one channel.
- Counter, WRAP=1: 2^COUNT_W-1 +1 -> 0; 0 -1 -> 2^COUNT_W-1.
- Counter, WRAP=0: holds at the limit. The pulse is still emitted at the limit; only the count saturates.
- i_Clear[c]: at the next edge, count<=0, accumulator<=0, error<=0, and that channel's pulse is suppressed for that cycle.
  - An ERR decoded in the same cycle as i_Clear still sets the error: set wins over clear.
  - r_Cur/r_Prev keep tracking, so no re-initialisation is needed.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.
- Reset mid-detent discards the partial accumulator. After release, re-init from the current pins.

Decomposition:
- Package quad_encoder_pkg contains:
  - enum dir_t {DIR_NONE, DIR_CW, DIR_CCW, DIR_ERR};
  - function decode(prev[1:0], cur[1:0]) returning dir_t;
  - a localparam helper for accumulator width from STEPS_PER_DETENT.
- Sub-module quad_channel (ports: one A/B pair, clear, left, right, count, error) holds all per-channel state.
- The top is a generate loop over CHANNELS plus output packing.

Test Plan:
All scenarios use CHANNELS=2, COUNT_W=4, STEPS_PER_DETENT=4, WRAP=1 unless noted. Each AB value is held 3 cycles.
1. Release reset with A=B=1 on both channels, then idle 20 cycles -> no o_Left/o_Right pulse, o_Count=0, o_Error=0.
2. Ch0 AB 00->10->11->01->00 -> exactly one o_Right[0] pulse, 1 cycle wide, 2 edges after 00 is sampled. o_Count ch0=1, ch1 unchanged. Rerun with STEPS_PER_DETENT=1 -> 4 pulses, count=4.
3. Ch0 four full CCW detents from count 0 -> 4 o_Left[0] pulses, count 15,14,13,12. Same with WRAP=0 -> 4 pulses, count stays 0.
4. Ch0 00->10->11 then back 11->10->00 -> no pulse, count unchanged, error 0. Concurrent ch1 CW detent -> o_Right[1] unaffected.
5. Ch0 00->11 in one sample -> o_Error[0]=1 and stays 1, no pulse. Next full CW detent -> count+1. Pulse i_Clear[0] -> count 0, error 0.
6. Assert i_Rst asynchronously after 00->10->11, between clock edges -> all outputs 0 before the next edge. Release with AB=11, then finish 01->00 -> no pulse, count 0.
